// File: rtl/plat_pkg.sv
// Shared types and constants for the platform-table sequencer.
package plat_pkg;

   typedef struct packed {
      logic       valid;
      logic [9:0] x;
      logic [9:0] y;
   } plat_t;

   typedef enum logic [2:0] {
      StIdle,
      StFill,
      StRd,
      StWait,
      StWr,
      StDone
   } seq_state_e;

   localparam logic [2:0]  OUTSTATE_REFRESH = 3'b100;
   // Galois taps 16,14,13,11 for a right-shifting register
   localparam logic [15:0] LFSR_TAPS        = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
      return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/plat_lfsr16.sv
// Free-running 16-bit Galois LFSR used for platform respawn x positions.
module plat_lfsr16
   import plat_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        Clock,
   input  logic        Reset,
   output logic [15:0] q
);

   logic [15:0] lfsr_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_step(lfsr_q);
      end
   end

   assign q = lfsr_q;

endmodule

// File: rtl/plat_refresh_seq.sv
// Platform table sequencer: initial fill on loadplat, scroll/respawn walk on Refreshing entry.
// Optional respawn counter port enabled by defining PLAT_RESPAWN_CNT_EN.
module plat_refresh_seq
   import plat_pkg::*;
#(
   parameter int unsigned N_PLAT    = 16,
   parameter int unsigned SCREEN_W  = 640,
   parameter int unsigned SCREEN_H  = 480,
   parameter int unsigned PLAT_PIX  = 64,
   parameter int unsigned ROW_SPACE = 30,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   localparam int unsigned IDX_W    = $clog2(N_PLAT)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [2:0]       outstate,
   input  logic             loadplat,
   input  logic [9:0]       scroll_dy,
   output logic [IDX_W-1:0] plat_addr,
   input  logic [20:0]      plat_rd_data,
   output logic             plat_wr_en,
   output logic [20:0]      plat_wr_data,
   output logic             busy,
   output logic             trigger
`ifdef PLAT_RESPAWN_CNT_EN
   ,
   output logic [15:0]      respawn_total
`endif
);

   localparam int unsigned XMAX = SCREEN_W - PLAT_PIX;

   seq_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             loadplat_q, rf_prev_q, ld_start_q, rf_start_q;
   logic             in_refresh, last_slot;
   logic [15:0]      lfsr;
   logic [9:0]       lfsr_lo, xr;
   logic [31:0]      fill_off;
   plat_t            fill_word, rd_word, wr_word;
   logic [10:0]      sum_y, over_y;
   logic             respawn;
   logic             unused_lfsr;

   plat_lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .Clock (Clock),
      .Reset (Reset),
      .q     (lfsr)
   );

   assign unused_lfsr = ^lfsr[15:10];
   assign lfsr_lo     = lfsr[9:0];
   assign xr          = (lfsr_lo >= 10'(XMAX)) ? lfsr_lo - 10'(XMAX) : lfsr_lo;
   assign in_refresh  = (outstate == OUTSTATE_REFRESH);
   assign last_slot   = (idx_q == IDX_W'(N_PLAT - 1));

   // Start requests live for one cycle; anything arriving outside IDLE is dropped
   always_ff @(posedge Clock) begin
      if (Reset) begin
         loadplat_q <= 1'b0;
         rf_prev_q  <= 1'b0;
         ld_start_q <= 1'b0;
         rf_start_q <= 1'b0;
      end else begin
         loadplat_q <= loadplat;
         rf_prev_q  <= in_refresh;
         ld_start_q <= loadplat & ~loadplat_q;
         rf_start_q <= in_refresh & ~rf_prev_q;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            idx_d = '0;
            if (ld_start_q) begin
               state_d = StFill;
            end else if (rf_start_q) begin
               state_d = StRd;
            end
         end
         StFill: begin
            if (last_slot) begin
               state_d = StIdle;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StRd:   state_d = StWait;
         StWait: state_d = StWr;
         StWr: begin
            if (last_slot) begin
               state_d = StDone;
            end else begin
               state_d = StRd;
               idx_d   = idx_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            idx_d   = '0;
         end
         default: begin
            state_d = StIdle;
            idx_d   = '0;
         end
      endcase
   end

   always_comb begin
      fill_off        = 32'(idx_q) * ROW_SPACE;
      fill_word.valid = (fill_off < SCREEN_H);
      fill_word.x     = xr;
      fill_word.y     = fill_word.valid ? 10'(SCREEN_H - 1 - fill_off) : 10'd0;
   end

   // Read word is stable in WR because plat_addr holds the slot through WAIT
   always_comb begin
      rd_word = plat_t'(plat_rd_data);
      sum_y   = {1'b0, rd_word.y} + {1'b0, scroll_dy};
      over_y  = sum_y - 11'(SCREEN_H);
      respawn = rd_word.valid && (sum_y >= 11'(SCREEN_H));
      wr_word = rd_word;
      if (rd_word.valid) begin
         if (!respawn) begin
            wr_word = '{valid: 1'b1, x: rd_word.x, y: sum_y[9:0]};
         end else begin
            wr_word.valid = 1'b1;
            wr_word.x     = xr;
            wr_word.y     = (over_y >= 11'(SCREEN_H)) ? 10'd0 : over_y[9:0];
         end
      end
   end

   always_comb begin
      plat_addr    = idx_q;
      plat_wr_en   = 1'b0;
      plat_wr_data = '0;
      busy         = (state_q != StIdle);
      trigger      = (state_q == StDone);
      if (state_q == StFill) begin
         plat_wr_en   = 1'b1;
         plat_wr_data = fill_word;
      end else if (state_q == StWr) begin
         plat_wr_en   = 1'b1;
         plat_wr_data = wr_word;
      end
   end

`ifdef PLAT_RESPAWN_CNT_EN
   logic [15:0] respawn_cnt_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         respawn_cnt_q <= '0;
      end else if (state_q == StIdle && ld_start_q) begin
         respawn_cnt_q <= '0;
      end else if (state_q == StWr && respawn && respawn_cnt_q != 16'hFFFF) begin
         respawn_cnt_q <= respawn_cnt_q + 16'd1;
      end
   end

   assign respawn_total = respawn_cnt_q;
`endif

endmodule
